// File: rtl/avalon_mem_if.sv
// Avalon-style memory bus bundle shared by the CPU master and the memory model.
interface avalon_mem_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_mem_model.sv
// Two-region byte-addressed Avalon memory slave with wait states, fault flag and counters.
// Define RANDOM_WAIT_EN to draw the per-transfer wait target from an 8-bit LFSR.
module avalon_mem_model #(
  parameter logic [31:0] DATA_BASE   = 32'h0000_0000,
  parameter int          DATA_BYTES  = 4096,
  parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
  parameter int          INSTR_BYTES = 4096,
  parameter int          WAIT_CYCLES = 0,
  parameter string       DATA_INIT   = "",
  parameter string       INSTR_INIT  = "",
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  avalon_mem_if.slave   bus,
  output logic          err,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int LANES = 4;
  localparam int DAW   = $clog2(DATA_BYTES);
  localparam int IAW   = $clog2(INSTR_BYTES);

  logic [7:0] dmem [DATA_BYTES];
  logic [7:0] imem [INSTR_BYTES];

  // Zero-filled image; contents deliberately survive reset.
  initial begin
    for (int i = 0; i < DATA_BYTES; i++)  dmem[i] = 8'h00;
    for (int i = 0; i < INSTR_BYTES; i++) imem[i] = 8'h00;
  end

  logic [3:0]  waitcnt;
  logic [3:0]  target;
  logic        req;
  logic        complete;
  logic        fault;
  logic        d_hit;
  logic        i_hit;
  logic [31:0] doff;
  logic [31:0] ioff;
  logic [31:0] rdata;

  assign req = bus.read | bus.write;

  // Unsigned offset wraps below the base, so one compare covers both bounds.
  assign doff  = bus.address - DATA_BASE;
  assign ioff  = bus.address - INSTR_BASE;
  assign d_hit = doff < 32'(DATA_BYTES);
  assign i_hit = ioff < 32'(INSTR_BYTES);

  assign fault = (bus.address[1:0] != 2'b00) | ~(d_hit | i_hit) |
                 (bus.read & bus.write) | (bus.byteenable == 4'h0);

`ifdef RANDOM_WAIT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         lfsr <= LFSR_SEED;
    else if (complete) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign target = (lfsr[3:0] < 4'(WAIT_CYCLES)) ? lfsr[3:0] : 4'(WAIT_CYCLES);
`else
  assign target = 4'(WAIT_CYCLES);
`endif

  assign bus.waitrequest = reset | (req & (waitcnt != target));
  assign complete        = req & ~bus.waitrequest;

  // Completion, abandonment and idle all return the counter to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        waitcnt <= 4'd0;
    else if (req && bus.waitrequest)  waitcnt <= waitcnt + 4'd1;
    else                              waitcnt <= 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (complete) begin
      if (fault)          err      <= 1'b1;
      else if (bus.read)  rd_count <= rd_count + 16'd1;
      else                wr_count <= wr_count + 16'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (complete && bus.read && !fault) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.byteenable[i])
          rdata[8*i +: 8] = d_hit ? dmem[{doff[DAW-1:2], 2'(i)}]
                                  : imem[{ioff[IAW-1:2], 2'(i)}];
      end
    end
  end

  assign bus.readdata = rdata;

  // Memory has no reset; waitrequest is high in reset so no write can slip through.
  always_ff @(posedge clk) begin
    if (complete && bus.write && !fault) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.byteenable[i]) begin
          if (d_hit) dmem[{doff[DAW-1:2], 2'(i)}] <= bus.writedata[8*i +: 8];
          else       imem[{ioff[IAW-1:2], 2'(i)}] <= bus.writedata[8*i +: 8];
        end
      end
    end
  end

endmodule
